// File: rtl/seven_segment.sv
// -----------------------------------------------------------------------------
// seven_segment
//
// BCD-to-seven-segment decoder for a common-cathode display. The 4-bit code
// N = {W,X,Y,Z} is decoded into seven active-high segment enables, and the
// result is registered so that the display pins are driven straight from
// flops with no combinational path from the inputs.
//
// Ports:
//   clk        - system clock, all state changes on its rising edge
//   rst        - synchronous active-high reset, blanks the display
//   W, X, Y, Z - BCD digit, W is the MSB (weight 8), Z the LSB (weight 1)
//   A .. G     - segment enables (1 = lit): a top, b top-right,
//                c bottom-right, d bottom, e bottom-left, f top-left,
//                g middle
// -----------------------------------------------------------------------------
module seven_segment (
    input  logic clk,
    input  logic rst,
    input  logic W,
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic F,
    output logic G
);

    // Segment vector ordering is {a,b,c,d,e,f,g}, MSB = segment a.
    logic [3:0] code;
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    assign code = {W, X, Y, Z};

    // Decode the current code. Codes 10..15 are not BCD and blank the
    // display rather than showing hex glyphs.
    always_comb begin
        seg_d = 7'b0000000;
        case (code)
            4'd0:    seg_d = 7'b1111110;
            4'd1:    seg_d = 7'b0110000;
            4'd2:    seg_d = 7'b1101101;
            4'd3:    seg_d = 7'b1111001;
            4'd4:    seg_d = 7'b0110011;
            4'd5:    seg_d = 7'b1011011;
            4'd6:    seg_d = 7'b1011111;
            4'd7:    seg_d = 7'b1110000;
            4'd8:    seg_d = 7'b1111111;
            4'd9:    seg_d = 7'b1111011;
            default: seg_d = 7'b0000000;
        endcase
    end

    // Output register; reset wins over the decoded value and blanks the
    // display on the edge where it is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'b0000000;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_seven_segment.sv
// -----------------------------------------------------------------------------
// tb_seven_segment
//
// Testbench for seven_segment. A reference model describes each segment by
// the set of digits that light it, registers that description on the same
// edge as the design, and a compare process checks the design against it on
// every falling edge once reset has been seen. Directed sequences add
// literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_seven_segment;

    logic clk;
    logic rst_in;
    logic w_in, x_in, y_in, z_in;
    logic a_out, b_out, c_out, d_out, e_out, f_out, g_out;

    int checks_done;
    int checks_failed;

    logic [6:0] model_seg;
    logic       model_valid;

    seven_segment dut (
        .clk (clk),
        .rst (rst_in),
        .W   (w_in),
        .X   (x_in),
        .Y   (y_in),
        .Z   (z_in),
        .A   (a_out),
        .B   (b_out),
        .C   (c_out),
        .D   (d_out),
        .E   (e_out),
        .F   (f_out),
        .G   (g_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each segment is described by the set of digits 0..9 that light it
    // (bit i of the mask set means digit i lights that segment). Anything
    // 10 or above is blank.
    function automatic logic [6:0] model_decode(input int n);
        logic [9:0] masks [7];
        logic [6:0] r;
        masks[0] = 10'h3ED;  // a: 0,2,3,5,6,7,8,9
        masks[1] = 10'h39F;  // b: 0,1,2,3,4,7,8,9
        masks[2] = 10'h3FB;  // c: all except 2
        masks[3] = 10'h36D;  // d: 0,2,3,5,6,8,9
        masks[4] = 10'h145;  // e: 0,2,6,8
        masks[5] = 10'h371;  // f: 0,4,5,6,8,9
        masks[6] = 10'h37C;  // g: 2,3,4,5,6,8,9
        r = 7'b0000000;
        if (n < 10) begin
            for (int s = 0; s < 7; s++) begin
                r[6 - s] = masks[s][n];
            end
        end
        return r;
    endfunction

    // Reference model register, updated on the same edge as the design.
    initial model_valid = 1'b0;
    always @(posedge clk) begin
        if (rst_in) begin
            model_seg   <= 7'b0000000;
            model_valid <= 1'b1;
        end else begin
            model_seg <= model_decode(int'({w_in, x_in, y_in, z_in}));
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checks_done++;
            if ({a_out, b_out, c_out, d_out, e_out, f_out, g_out} !== model_seg) begin
                checks_failed++;
                $display("[TB] FAIL model_compare t=%0t got=%b expected=%b", $time,
                         {a_out, b_out, c_out, d_out, e_out, f_out, g_out}, model_seg);
            end
        end
    end

    // Drive reset and code, then step past the next rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] n);
        rst_in = r;
        {w_in, x_in, y_in, z_in} = n;
        @(posedge clk);
        #1;
    endtask

    // Literal check of the current outputs.
    task automatic checkOutput(input string name, input logic [6:0] expected);
        checks_done++;
        if ({a_out, b_out, c_out, d_out, e_out, f_out, g_out} !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s got=%b expected=%b", name,
                     {a_out, b_out, c_out, d_out, e_out, f_out, g_out}, expected);
        end
    endtask

    // Literal segment patterns for digits 0..9 as written in the decode table.
    logic [6:0] digit_table [10];

    initial begin
        digit_table[0] = 7'b1111110;
        digit_table[1] = 7'b0110000;
        digit_table[2] = 7'b1101101;
        digit_table[3] = 7'b1111001;
        digit_table[4] = 7'b0110011;
        digit_table[5] = 7'b1011011;
        digit_table[6] = 7'b1011111;
        digit_table[7] = 7'b1110000;
        digit_table[8] = 7'b1111111;
        digit_table[9] = 7'b1111011;

        checks_done   = 0;
        checks_failed = 0;
        rst_in = 1'b1;
        {w_in, x_in, y_in, z_in} = 4'd8;

        // Reset held for two edges with an 8 on the inputs, then release.
        applyStimulus(1'b1, 4'd8);
        checkOutput("reset_edge1", 7'b0000000);
        applyStimulus(1'b1, 4'd8);
        checkOutput("reset_edge2", 7'b0000000);
        applyStimulus(1'b0, 4'd8);
        checkOutput("reset_release", 7'b1111111);

        // Ascending digit sweep.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'(i));
            checkOutput($sformatf("digit_%0d", i), digit_table[i]);
        end
        checkOutput("digit_9_explicit", 7'b1111011);

        // Non-BCD codes blank the display, then a valid code recovers.
        for (int i = 10; i < 16; i++) begin
            applyStimulus(1'b0, 4'(i));
            checkOutput($sformatf("invalid_%0d", i), 7'b0000000);
        end
        applyStimulus(1'b0, 4'd5);
        checkOutput("after_invalid_5", 7'b1011011);

        // One-cycle reset pulse while showing 8.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd8);
        end
        checkOutput("mid_op_8", 7'b1111111);
        applyStimulus(1'b1, 4'd8);
        checkOutput("mid_op_reset", 7'b0000000);
        applyStimulus(1'b0, 4'd8);
        checkOutput("mid_op_resume", 7'b1111111);

        // Reset held while inputs change keeps the display blank.
        applyStimulus(1'b1, 4'd0);
        checkOutput("held_reset_0", 7'b0000000);
        applyStimulus(1'b1, 4'd7);
        checkOutput("held_reset_7", 7'b0000000);

        // Back-to-back alternation between 1 and 8.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 4'd1 : 4'd8);
            checkOutput($sformatf("alternate_%0d", i),
                        (i % 2 == 0) ? 7'b0110000 : 7'b1111111);
        end

        // Mid-cycle change: 3 then 4 before the edge; only 4 is decoded and
        // the outputs hold the previous value (8) until that edge.
        rst_in = 1'b0;
        {w_in, x_in, y_in, z_in} = 4'd3;
        #3;
        checkOutput("hold_before_edge_a", 7'b1111111);
        {w_in, x_in, y_in, z_in} = 4'd4;
        #3;
        checkOutput("hold_before_edge_b", 7'b1111111);
        @(posedge clk);
        #1;
        checkOutput("mid_cycle_4", 7'b0110011);

        // Mid-cycle change with reset asserted between edges has no effect yet.
        rst_in = 1'b1;
        #3;
        checkOutput("reset_between_edges", 7'b0110011);
        @(posedge clk);
        #1;
        checkOutput("reset_at_edge", 7'b0000000);

        rst_in = 1'b0;
        @(posedge clk);
        #6;

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 checks_done, checks_failed);
        $finish;
    end

endmodule
